// File: rtl/sort_mem_controller.sv
// Memory arbiter plus in-place bubble-sort engine for the 8-bit data memory.
// Idle: CPU signals pass straight to memory. After start: engine owns the port until done.
module sort_mem_controller #(
    parameter int DW       = 8,
    parameter int AW       = 8,
    parameter int ADDR_N   = 2,
    parameter int BASE_VEC = 4,
    parameter int MAX_LEN  = 12
) (
    input  logic          clock,
    input  logic          resetn,
    input  logic          start,
    input  logic          cpu_write,
    input  logic          cpu_read,
    input  logic [AW-1:0] cpu_index,
    input  logic [DW-1:0] cpu_dado_in,
    output logic [DW-1:0] cpu_dado_out,
    output logic          cpu_wait,
    output logic          mem_write,
    output logic          mem_read,
    output logic [AW-1:0] mem_index,
    output logic [DW-1:0] mem_dado_out,
    input  logic [DW-1:0] mem_dado_in,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [7:0]    swap_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_N,
        S_READ_A,
        S_READ_B,
        S_WRITE_A,
        S_WRITE_B,
        S_PASS_END,
        S_DONE
    } state_t;

    state_t        state;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [DW-1:0] n;
    logic [AW-1:0] i;
    logic [AW-1:0] j;
    logic          swapped;

    logic [AW-1:0] n_idx;
    logic [AW-1:0] j_inc;
    logic [AW-1:0] pass_limit;
    logic          more_pairs;
    logic          last_pass;
    logic [AW-1:0] vec_j;
    logic [AW-1:0] vec_j1;

    // Pass i compares pairs j = 0 .. n-2-i; the last pass is i = n-2.
    assign n_idx      = AW'(n);
    assign j_inc      = j + AW'(1);
    assign pass_limit = n_idx - AW'(1) - i;
    assign more_pairs = (j_inc < pass_limit);
    assign last_pass  = ((i + AW'(1)) == (n_idx - AW'(1)));
    assign vec_j      = AW'(BASE_VEC) + j;
    assign vec_j1     = vec_j + AW'(1);

    assign cpu_wait = busy;

    always_comb begin
        mem_write    = 1'b0;
        mem_read     = 1'b0;
        mem_index    = '0;
        mem_dado_out = '0;
        cpu_dado_out = '0;
        unique case (state)
            S_IDLE: begin
                mem_write    = cpu_write;
                mem_read     = cpu_read;
                mem_index    = cpu_index;
                mem_dado_out = cpu_dado_in;
                cpu_dado_out = mem_dado_in;
            end
            S_LOAD_N: begin
                mem_read  = 1'b1;
                mem_index = AW'(ADDR_N);
            end
            S_READ_A: begin
                mem_read  = 1'b1;
                mem_index = vec_j;
            end
            S_READ_B: begin
                mem_read  = 1'b1;
                mem_index = vec_j1;
            end
            S_WRITE_A: begin
                mem_write    = 1'b1;
                mem_index    = vec_j;
                mem_dado_out = b;
            end
            S_WRITE_B: begin
                mem_write    = 1'b1;
                mem_index    = vec_j1;
                mem_dado_out = a;
            end
            default: begin
                mem_write = 1'b0;
            end
        endcase
    end

    // busy and done are registered alongside the state transition that produces them.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state      <= S_IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            swap_count <= 8'd0;
            a          <= '0;
            b          <= '0;
            n          <= '0;
            i          <= '0;
            j          <= '0;
            swapped    <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        err        <= 1'b0;
                        swap_count <= 8'd0;
                        i          <= '0;
                        j          <= '0;
                        swapped    <= 1'b0;
                        busy       <= 1'b1;
                        state      <= S_LOAD_N;
                    end
                end
                S_LOAD_N: begin
                    n <= mem_dado_in;
                    if (mem_dado_in > DW'(MAX_LEN)) begin
                        err   <= 1'b1;
                        done  <= 1'b1;
                        state <= S_DONE;
                    end else if (mem_dado_in < DW'(2)) begin
                        done  <= 1'b1;
                        state <= S_DONE;
                    end else begin
                        state <= S_READ_A;
                    end
                end
                S_READ_A: begin
                    a     <= mem_dado_in;
                    state <= S_READ_B;
                end
                S_READ_B: begin
                    b <= mem_dado_in;
                    if (a > mem_dado_in) begin
                        state <= S_WRITE_A;
                    end else if (more_pairs) begin
                        j     <= j_inc;
                        state <= S_READ_A;
                    end else begin
                        state <= S_PASS_END;
                    end
                end
                S_WRITE_A: begin
                    state <= S_WRITE_B;
                end
                S_WRITE_B: begin
                    swapped <= 1'b1;
                    if (swap_count != 8'hFF) begin
                        swap_count <= swap_count + 8'd1;
                    end
                    if (more_pairs) begin
                        j     <= j_inc;
                        state <= S_READ_A;
                    end else begin
                        state <= S_PASS_END;
                    end
                end
                S_PASS_END: begin
                    if (!swapped || last_pass) begin
                        done  <= 1'b1;
                        state <= S_DONE;
                    end else begin
                        i       <= i + AW'(1);
                        j       <= '0;
                        swapped <= 1'b0;
                        state   <= S_READ_A;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/sort_mem_controller.md
Name: sort_mem_controller

Overview:
- Sequencer/arbiter in front of the 8-bit data memory. Sits between the CPU datapath and the memory.
- When idle, CPU memory signals pass straight through to the memory.
- On a start pulse, the block takes ownership of the memory port. It reads length n from a fixed address and bubble-sorts the vector region in place, ascending and unsigned. It then returns the port to the CPU.

Parameters:
- DW, 8, data width
- AW, 8, address (index) width
- ADDR_N, 2, memory address holding vector length n
- BASE_VEC, 4, address of v[0]
- MAX_LEN, 12, largest legal n

Ports:
- clock  in  1  single clock; all state updates on posedge
- resetn  in  1  asynchronous, active-low reset
- start  in  1  request a sort; sampled only in IDLE
- cpu_write  in  1  CPU write strobe
- cpu_read  in  1  CPU read enable
- cpu_index  in  AW  CPU address
- cpu_dado_in  in  DW  CPU write data
- cpu_dado_out  out  DW  CPU read data
- cpu_wait  out  1  memory owned by engine; CPU access dropped
- mem_write  out  1  to memory write
- mem_read  out  1  to memory read
- mem_index  out  AW  to memory index
- mem_dado_out  out  DW  to memory dadoEntrada
- mem_dado_in  in  DW  from memory dadoSaida; combinational read, same cycle
- busy  out  1  sort in progress
- done  out  1  one-cycle pulse at end of sort
- err  out  1  n > MAX_LEN on last sort; sticky until next accepted start
- swap_count  out  8  swaps performed in last sort; saturates at 255

Behaviour:
- Reset (async, resetn=0):
  - State goes to IDLE; busy, done, err, cpu_wait = 0; swap_count = 0.
  - Internal a, b, n, i, j, swapped = 0.
  - mem_write = 0 immediately.
  - Memory contents are not restored; an aborted sort may leave the vector partially sorted.
- Port mux:
  - In IDLE: mem_* = cpu_* and cpu_dado_out = mem_dado_in.
  - Otherwise: engine drives mem_*, cpu_dado_out = 0, cpu_wait = 1, and CPU writes are discarded.
- State machine (one state per cycle):
  - IDLE: if start=1, clear err, swap_count, i, j, swapped; go to LOAD_N. start while busy is ignored.
  - LOAD_N: mem_read=1, index=ADDR_N; latch n.
    - If n > MAX_LEN: set err, go to DONE.
    - Else if n < 2: go to DONE.
    - Else go to READ_A.
  - READ_A: read BASE_VEC+j; latch a.
  - READ_B: read BASE_VEC+j+1; compare latched a with mem_dado_in (b, also latched).
    - If a > b: go to WRITE_A.
    - Else: ADVANCE inline.
  - WRITE_A: mem_write=1, index=BASE_VEC+j, data=b.
  - WRITE_B: mem_write=1, index=BASE_VEC+j+1, data=a; set swapped; swap_count += 1 (saturating); then ADVANCE.
  - ADVANCE (no extra cycle):
    - If j+1 < n-1-i: j++, go to READ_A.
    - Else go to PASS_END.
  - PASS_END:
    - If swapped=0 or i+1 = n-1: go to DONE.
    - Else i++, j=0, swapped=0, go to READ_A.
  - DONE: done=1 for exactly this cycle; go to IDLE.
- busy = 1 in every state except IDLE.
- Writes land at the posedge ending WRITE_A/WRITE_B. mem_write is never asserted in any other engine state.
- Comparisons are unsigned 8-bit. Equal elements are not swapped, so the sort is stable.
- All address arithmetic is AW bits wide. With the default parameters no wrap-around is reachable.

Test Plan:
- Memory[2]=5, [4..8]=9,8,7,6,5; pulse start → memory [4..8]=5,6,7,8,9; swap_count=10; err=0; single done pulse; memory addresses 0,1,3 untouched.
- Memory[2]=5, [4..8]=1,2,3,4,5 → no mem_write asserted; busy high exactly 11 cycles (LOAD_N + 8 reads + PASS_END + DONE); done on the 11th; swap_count=0.
- Memory[2]=13 → err=1, done after 2 busy cycles, no writes. A following start with n=5 clears err.
- Memory[2]=1, then n=0 → done after 2 busy cycles, err=0, swap_count=0, no writes.
- While busy: CPU writes 8'hAA to address 0 and reads address 2 → cpu_wait=1, cpu_dado_out=0, memory[0] unchanged. A second start mid-sort is ignored; exactly one done pulse. After done, the CPU read of address 2 returns 5.
- Drive resetn low in the cycle after WRITE_A of the first swap (9,8,... input) → busy/done/cpu_wait drop asynchronously, mem_write=0. Memory [4..5]=8,8 remains. After release, a new start completes the sort correctly.
